wbgpio_irq: RTL and testbench
=============================

Name: wbgpio_irq

Overview:
- Parametrised successor to the single-register wishbone GPIO port.
- Up to 16 bidirectional pins, with per-pin direction and per-pin interrupt configuration (rising/falling edge select, enable).
- Latched pending status is cleared by write-1-to-clear.
- Sits on the 32-bit peripheral wishbone bus; o_int feeds the CPU interrupt controller.

Parameters:
- NPINS, 16, number of GPIO pins (1..16); unused register bits read 0, ignored on write.
- DEFAULT_OUT, 16'h0000, reset value of output latch (low NPINS bits used).
- DEFAULT_DIR, 16'h0000, reset value of direction register (1 = output).
- DEBOUNCE, 4, stable-cycle count for input filter (only with WBGPIO_DEBOUNCE_EN; 2..255).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc  in  1  wishbone cycle
- i_wb_stb  in  1  wishbone strobe
- i_wb_we  in  1  write enable
- i_wb_addr  in  3  word address
- i_wb_data  in  32  write data
- o_wb_ack  out  1  acknowledge
- o_wb_stall  out  1  tied 0
- o_wb_data  out  32  read data
- i_gpio  in  NPINS  raw pad inputs (asynchronous)
- o_gpio  out  NPINS  output latch
- o_gpio_oe  out  NPINS  output enable (= DIR)
- o_int  out  1  level interrupt

Behaviour:
- Reset (async, i_reset high): OUT=DEFAULT_OUT, DIR=DEFAULT_DIR, IE=0, RISE=0, FALL=0, PEND=0, o_wb_ack=0, o_wb_data=0, o_int=0, sync stages=0, prime counter=0.
- Bus access = i_wb_cyc & i_wb_stb. Every access is acked exactly one cycle later (o_wb_ack registered), including unmapped addresses. No stall.
- o_wb_data is registered together with ack; 0 when not acked.
- Register map (word address):
  - 0 DATA: read {in_sync[15:0], OUT[15:0]}. Write: OUT = (OUT & ~d[31:16]) | (d[15:0] & d[31:16]).
  - 1 DIR: read {16'h0, DIR}. Write uses the same mask/value scheme as DATA.
  - 2 IE: read {16'h0, IE}. Write uses the same mask/value scheme.
  - 3 EDGE: read {FALL, RISE}. Write loads d[15:0]→RISE and d[31:16]→FALL directly.
  - 4 PEND: read {16'h0, PEND}. Write: bits set in d[15:0] are cleared (W1C).
  - 5..7: read 0; writes ignored.
- Writes take effect on the cycle after the accepted strobe, i.e. the cycle ack is asserted.
- Input path: 2-FF synchroniser (s1, s2) plus history register s3 (s3 <= s2).
  - in_sync = s2.
  - Pins configured as outputs are still sampled; DATA upper bits reflect the pad.
- Edge detect per pin i:
  - rise_i = s2 & ~s3; fall_i = ~s2 & s3.
  - evt_i = (rise_i & RISE_i) | (fall_i & FALL_i).
- Prime: a 2-bit counter counts to 3 after reset. evt is forced to 0 until it saturates, so no spurious edge fires as the synchroniser fills.
- PEND_i <= (PEND_i & ~clr_i) | evt_i. Set wins when an event and a W1C hit the same bit in the same cycle.
- Events latch into PEND regardless of IE. IE only gates the interrupt.
- o_int is registered: o_int <= |(PEND & IE). Latency from pad edge to o_int = 4 cycles (s1, s2/evt, PEND, o_int).
- Writing IE to enable an already-pending bit asserts o_int 2 cycles after the strobe.
- Reset asserted mid-transaction: ack is dropped immediately; the transaction is lost; the master must retry.
- Bits ≥ NPINS: read 0, never pend, ignored on write.

Optional Feature:
- Macro: WBGPIO_DEBOUNCE_EN.
- Defined:
  - Each pin gets an 8-bit counter between s2 and the edge detector.
  - Filtered value f_i updates to s2_i only after s2_i has differed from f_i for DEBOUNCE consecutive cycles. Any return to f_i resets the counter.
  - in_sync and edge detection use f instead of s2. Reset value of f = 0.
  - Pad-to-o_int latency = 4 + DEBOUNCE cycles.
- Undefined: no counters; behaviour as above.

Test Plan:
- Reset with DEFAULT_OUT=16'h00A5, DEFAULT_DIR=16'h00FF → o_gpio=A5, o_gpio_oe=FF, o_int=0. Read addr 0 with i_gpio=0 → 0x000000A5.
- Write 0x00030001 to addr 0 → o_gpio bit0=1, bit1=0, other bits unchanged. Ack exactly 1 cycle after strobe. Write 0x00010000 → bit0=0.
- Write 0x00000004 to EDGE (RISE bit2) and 0x00040004 to IE, then raise i_gpio[2] → PEND=0x4 and o_int=1 four cycles after the pad edge. Falling edge on pin 2 → no new event.
- W1C 0x4 to PEND in the same cycle a new rising evt hits pin 2 → PEND bit2 stays 1, o_int stays 1. W1C on a later quiet cycle → PEND=0, o_int=0 one cycle after the clear lands.
- IE=0 with FALL enabled on pin 5; drive pin 5 low → PEND=0x20, o_int=0. Then write 0x00200020 to IE → o_int=1. Read addr 6 → 0, still acked.
- WBGPIO_DEBOUNCE_EN, DEBOUNCE=4, RISE on pin 0: glitch i_gpio[0] high for 3 cycles → no PEND. Hold high ≥4 cycles → PEND bit0 set. Assert i_reset mid-glitch → all state returns to reset values.

Source files
------------

// File: rtl/wbgpio_irq.sv
// Wishbone GPIO port: up to 16 pins with direction, edge-selectable latched interrupts and W1C pending.
// Optional input debounce filter enabled by defining WBGPIO_DEBOUNCE_EN.
module wbgpio_irq #(
  parameter int          NPINS       = 16,
  parameter logic [15:0] DEFAULT_OUT = 16'h0000,
  parameter logic [15:0] DEFAULT_DIR = 16'h0000,
  parameter int          DEBOUNCE    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [2:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_ack,
  output logic             o_wb_stall,
  output logic [31:0]      o_wb_data,
  input  logic [NPINS-1:0] i_gpio,
  output logic [NPINS-1:0] o_gpio,
  output logic [NPINS-1:0] o_gpio_oe,
  output logic             o_int
);

  localparam logic [15:0] PIN_MASK = 16'((32'd1 << NPINS) - 32'd1);

  typedef enum logic [2:0] {
    A_DATA = 3'd0,
    A_DIR  = 3'd1,
    A_IE   = 3'd2,
    A_EDGE = 3'd3,
    A_PEND = 3'd4
  } addr_e;

  logic [15:0] out_r, dir_r, ie_r, rise_r, fall_r, pend_r;
  logic [15:0] pad, s1, s2, s3, lvl;
  logic [15:0] rise_e, fall_e, evt, clr;
  logic [1:0]  prime;
  logic [31:0] rd_val;
  logic        access, wr;

  function automatic logic [15:0] mask_write(input logic [15:0] cur, input logic [31:0] d);
    return ((cur & ~d[31:16]) | (d[15:0] & d[31:16])) & PIN_MASK;
  endfunction

  always_comb begin
    pad = '0;
    pad[NPINS-1:0] = i_gpio;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      prime <= '0;
    end else begin
      s1 <= pad & PIN_MASK;
      s2 <= s1;
      s3 <= lvl;
      if (prime != 2'd3) prime <= prime + 2'd1;
    end
  end

`ifdef WBGPIO_DEBOUNCE_EN
  logic [15:0] filt;
  logic [7:0]  cnt [16];

  // A pin's filtered level follows s2 only after DEBOUNCE consecutive differing samples.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      filt <= '0;
      for (int unsigned i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (s2[i] != filt[i]) begin
          if (cnt[i] == 8'(DEBOUNCE - 1)) begin
            filt[i] <= s2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  assign rise_e = lvl & ~s3;
  assign fall_e = ~lvl & s3;
  // Edges are suppressed until the synchroniser/history pipeline has filled after reset.
  assign evt    = (prime == 2'd3) ? (((rise_e & rise_r) | (fall_e & fall_r)) & PIN_MASK) : '0;

  assign access = i_wb_cyc & i_wb_stb;
  assign wr     = access & i_wb_we;
  assign clr    = (wr && i_wb_addr == A_PEND) ? i_wb_data[15:0] : '0;

  always_comb begin
    rd_val = '0;
    case (i_wb_addr)
      A_DATA:  rd_val = {lvl & PIN_MASK, out_r};
      A_DIR:   rd_val = {16'h0000, dir_r};
      A_IE:    rd_val = {16'h0000, ie_r};
      A_EDGE:  rd_val = {fall_r, rise_r};
      A_PEND:  rd_val = {16'h0000, pend_r};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_r     <= DEFAULT_OUT & PIN_MASK;
      dir_r     <= DEFAULT_DIR & PIN_MASK;
      ie_r      <= '0;
      rise_r    <= '0;
      fall_r    <= '0;
      pend_r    <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      o_int     <= 1'b0;
    end else begin
      o_wb_ack  <= access;
      o_wb_data <= (access && !i_wb_we) ? rd_val : '0;
      if (wr) begin
        case (i_wb_addr)
          A_DATA: out_r <= mask_write(out_r, i_wb_data);
          A_DIR:  dir_r <= mask_write(dir_r, i_wb_data);
          A_IE:   ie_r  <= mask_write(ie_r, i_wb_data);
          A_EDGE: begin
            rise_r <= i_wb_data[15:0] & PIN_MASK;
            fall_r <= i_wb_data[31:16] & PIN_MASK;
          end
          default: ;
        endcase
      end
      // A new event wins over a simultaneous clear of the same bit.
      pend_r <= ((pend_r & ~clr) | evt) & PIN_MASK;
      o_int  <= |(pend_r & ie_r);
    end
  end

  assign o_gpio     = out_r[NPINS-1:0];
  assign o_gpio_oe  = dir_r[NPINS-1:0];
  assign o_wb_stall = 1'b0;

endmodule

// File: tb/tb_wbgpio_irq.sv
// Directed self-checking bench for wbgpio_irq: bus access, mask writes, edge interrupts, W1C, reset.
module tb_wbgpio_irq;

`ifdef WBGPIO_DEBOUNCE_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [2:0]  adr;
  logic [31:0] wdat;
  logic        ack, stall, irq;
  logic [31:0] rdat;
  logic [15:0] gpio_in, gpio_out, gpio_oe;
  logic [31:0] rd;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  wbgpio_irq #(
    .NPINS(16),
    .DEFAULT_OUT(16'h00A5),
    .DEFAULT_DIR(16'h00FF),
    .DEBOUNCE(4)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_wb_cyc(cyc),
    .i_wb_stb(stb),
    .i_wb_we(we),
    .i_wb_addr(adr),
    .i_wb_data(wdat),
    .o_wb_ack(ack),
    .o_wb_stall(stall),
    .o_wb_data(rdat),
    .i_gpio(gpio_in),
    .o_gpio(gpio_out),
    .o_gpio_oe(gpio_oe),
    .o_int(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; strobe is sampled at the next posedge, ack checked at the following negedge.
  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(negedge clk);
    check("wr_ack", {31'b0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] v);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(negedge clk);
    check("rd_ack", {31'b0, ack}, 32'd1);
    v = rdat;
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; gpio_in = '0;
    tick(2);
    check("rst_gpio", {16'h0, gpio_out}, 32'h00A5);
    check("rst_oe", {16'h0, gpio_oe}, 32'h00FF);
    check("rst_int", {31'b0, irq}, 32'd0);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    tick(4);
    wb_read(3'd0, rd); check("data_rst", rd, 32'h000000A5);
    tick(1);
    check("ack_drop", {31'b0, ack}, 32'd0);
    check("data_idle", rdat, 32'd0);

    // Mask/value writes to the output latch and direction register
    wb_write(3'd0, 32'h00030001); check("out_1", {16'h0, gpio_out}, 32'h00A5);
    wb_write(3'd0, 32'h00010000); check("out_2", {16'h0, gpio_out}, 32'h00A4);
    wb_write(3'd0, 32'h00030002); check("out_3", {16'h0, gpio_out}, 32'h00A6);
    wb_write(3'd1, 32'h00F00000); check("oe_1", {16'h0, gpio_oe}, 32'h000F);
    wb_read(3'd1, rd); check("dir_rd", rd, 32'h0000000F);

    // Rising-edge interrupt on pin 2
    wb_write(3'd3, 32'h00000004);
    wb_write(3'd2, 32'h00040004);
    wb_read(3'd3, rd); check("edge_rd", rd, 32'h00000004);
    wb_read(3'd2, rd); check("ie_rd", rd, 32'h00000004);
    gpio_in[2] = 1'b1;
    tick(3 + EXTRA); check("int_early", {31'b0, irq}, 32'd0);
    tick(1);         check("int_lat", {31'b0, irq}, 32'd1);
    wb_read(3'd4, rd); check("pend_rise", rd, 32'h00000004);
    wb_read(3'd0, rd); check("data_pad", rd, 32'h000400A6);
    wb_write(3'd4, 32'h00000004); check("int_hold", {31'b0, irq}, 32'd1);
    tick(1);                      check("int_clr", {31'b0, irq}, 32'd0);
    wb_read(3'd4, rd); check("pend_clr", rd, 32'h00000000);

    // Falling edge with only RISE enabled must not pend
    gpio_in[2] = 1'b0;
    tick(8 + EXTRA);
    wb_read(3'd4, rd); check("pend_fall", rd, 32'h00000000);
    check("int_fall", {31'b0, irq}, 32'd0);

    // W1C landing in the same cycle as a new event: set wins
    gpio_in[2] = 1'b1;
    tick(2 + EXTRA);
    wb_write(3'd4, 32'h00000004);
    tick(1); check("int_setwin", {31'b0, irq}, 32'd1);
    wb_read(3'd4, rd); check("pend_setwin", rd, 32'h00000004);
    tick(4);
    wb_write(3'd4, 32'h00000004); check("int_hold2", {31'b0, irq}, 32'd1);
    tick(1);                      check("int_clr2", {31'b0, irq}, 32'd0);
    wb_read(3'd4, rd); check("pend_clr2", rd, 32'h00000000);

    // Falling edge on pin 5 pends with IE off; enabling IE then raises o_int
    gpio_in[5] = 1'b1;
    tick(6 + EXTRA);
    wb_write(3'd3, 32'h00200000);
    wb_write(3'd2, 32'h00040000);
    wb_read(3'd2, rd); check("ie_off", rd, 32'h00000000);
    gpio_in[5] = 1'b0;
    tick(6 + EXTRA);
    wb_read(3'd4, rd); check("pend_fall5", rd, 32'h00000020);
    check("int_noie", {31'b0, irq}, 32'd0);
    wb_write(3'd2, 32'h00200020); check("int_ie_1", {31'b0, irq}, 32'd0);
    tick(1);                      check("int_ie_2", {31'b0, irq}, 32'd1);
    wb_read(3'd6, rd); check("unmapped", rd, 32'h00000000);
    wb_write(3'd7, 32'hFFFFFFFF);
    wb_read(3'd0, rd); check("data_after7", rd, 32'h000400A6);
    wb_read(3'd3, rd); check("edge_rd2", rd, 32'h00200000);

    // Reset in the middle of an acked transaction
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 3'd4;
    @(posedge clk); #2;
    check("mid_ack", {31'b0, ack}, 32'd1);
    rst = 1'b1; #1;
    check("mid_ack_drop", {31'b0, ack}, 32'd0);
    check("mid_data", rdat, 32'd0);
    check("mid_int", {31'b0, irq}, 32'd0);
    check("mid_gpio", {16'h0, gpio_out}, 32'h00A5);
    check("mid_oe", {16'h0, gpio_oe}, 32'h00FF);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(4);
    wb_read(3'd4, rd); check("post_pend", rd, 32'h00000000);
    wb_read(3'd2, rd); check("post_ie", rd, 32'h00000000);
    wb_read(3'd3, rd); check("post_edge", rd, 32'h00000000);
    wb_read(3'd1, rd); check("post_dir", rd, 32'h000000FF);

`ifdef WBGPIO_DEBOUNCE_EN
    // Debounce: 3-cycle glitch is filtered, a sustained level is not
    wb_write(3'd3, 32'h00000001);
    gpio_in[0] = 1'b1; tick(3); gpio_in[0] = 1'b0;
    tick(12);
    wb_read(3'd4, rd); check("db_glitch", rd, 32'h00000000);
    gpio_in[0] = 1'b1;
    tick(16);
    wb_read(3'd4, rd); check("db_hold", rd, 32'h00000001);
    gpio_in[0] = 1'b0;
    tick(12);
    wb_write(3'd4, 32'h00000001);
    gpio_in[0] = 1'b1; tick(2);
    rst = 1'b1; tick(1);
    check("db_rst_gpio", {16'h0, gpio_out}, 32'h00A5);
    check("db_rst_int", {31'b0, irq}, 32'd0);
    rst = 1'b0; gpio_in[0] = 1'b0;
    tick(12);
    wb_read(3'd4, rd); check("db_rst_pend", rd, 32'h00000000);
    wb_read(3'd3, rd); check("db_rst_edge", rd, 32'h00000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
